fetch_decode_unit: RTL
======================

// Module: fetch_decode_unit
// PURPOSE
//   Program sequencer placed directly upstream of the 4-bit ALU/accumulator datapath.
//   Holds a program counter and fetches 8-bit instruction bytes from an external
//   combinational program ROM, then decodes them. Drives the ALU command, the operand
//   nibble, and the three datapath enables (bus buffer, accumulator, output buffer).
//   Latches the ALU carry/zero results into internal flags for use by conditional jumps.
// PARAMETERS
//   ADDR_W        12       PC width; jump target {operand,byte2} zero-extended to ADDR_W
//   RESET_VECTOR  0        PC value loaded on reset
// PORTS
//   Clk           in   1       system clock, rising edge
//   reset         in   1       asynchronous reset, active-low
//   en            in   1       run enable; 0 = stall in current state
//   program_byte  in   8       ROM data for address pc, valid same cycle
//   carry_in      in   1       ALU carry output
//   zero_in       in   1       ALU zero output (exit)
//   pc            out  ADDR_W  ROM address
//   operand       out  4       immediate nibble driven onto B bus
//   command       out  3       ALU command
//   bus_en        out  1       enables operand tristate onto B bus (En1)
//   acc_en        out  1       accumulator load enable (En)
//   out_en        out  1       output tristate enable (En2)
//   flag_c        out  1       latched carry
//   flag_z        out  1       latched zero
//   halted        out  1       1 while in HALT
// BEHAVIOUR
//   Reset (reset=0, async): pc=RESET_VECTOR, state=FETCH, all other outputs/flags=0.
//   Byte format: [7:4]=opcode, [3:0]=operand. Jumps carry a second byte holding target[7:0].
//   Opcodes: 1 LIT cmd=010 bus,acc,flags | 2 ADDI cmd=011 bus,acc,flags | 3 CMPI cmd=001 bus,flags
//     4 NANDI cmd=100 bus,acc | 5 OUT cmd=000 out_en | 0 NOP | 6 JMP | 7 JC | 8 JNC | 9 JZ
//     A JNZ | F HALT | B-E reserved.
//   FSM: FETCH -> EXEC (non-jump), FETCH -> FETCH_ADDR (jump), FETCH -> HALT (F).
//   FETCH: latch instruction byte, pc<=pc+1; all enables 0.
//   EXEC (1 cycle): command/operand/enables registered and valid for the entire cycle;
//     at the closing edge, flags<= {carry_in,zero_in} if the op updates flags; next state FETCH.
//   FETCH_ADDR: condition evaluated on the flags as they stand at entry;
//     if taken pc<={operand,program_byte}, else pc<=pc+1; next state FETCH.
//   Throughput: every instruction takes 2 cycles (jumps included).
//   HALT: stays until reset; halted=1; enables 0; pc frozen.
//   en=0: state, pc, and flags hold; bus_en/acc_en/out_en forced 0.
//     The interrupted EXEC reissues once en returns to 1.
//   pc wraps modulo 2^ADDR_W (e.g. 0xFFF+1=0x000). The second byte of a jump located
//     at 0xFFF is fetched from 0x000.
//   NANDI/OUT/NOP: flags unchanged. command holds its last value outside EXEC.
//   Reset asserted mid-instruction: immediate abort; no flag or pc update is completed.
// CONFIGURATION
//   ILLEGAL_TRAP_EN defined: a reserved opcode (B-E) goes to HALT and sets the output
//     illegal_op (1 bit, port added) to 1 until reset.
//   Not defined: a reserved opcode executes as NOP (2 cycles, no enables); no illegal_op port.
// TESTING
//   Release reset, ROM[0]=0x17 -> cycle 2: command=010, operand=7, bus_en=acc_en=1; pc=1.
//   LIT 0xF; ADDI 0x1 with carry_in=1, zero_in=1 on the ADDI EXEC -> flag_c=1, flag_z=1.
//   JC 0x2/0x34 with flag_c=1 -> pc=0x234 after FETCH_ADDR; with flag_c=0 -> pc=prev+2.
//   en=0 held 3 cycles during EXEC of OUT -> out_en=0 throughout; pulses 1 cycle after en=1.
//   pc at 0xFFF executing JMP -> second byte read at 0x000; NOP at 0xFFF -> next pc=0x000.
//   reset pulsed low mid-FETCH_ADDR -> pc=0, flags=0 immediately; F0 -> halted=1,
//     pc frozen; 0xB0 -> NOP, or HALT+illegal_op=1 with ILLEGAL_TRAP_EN.

Source files
------------

// File: rtl/fetch_decode_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | fetch_decode_unit_if                                                    |
// | ROM fetch port and ALU datapath control bundle of the program sequencer.|
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface fetch_decode_unit_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] pc;
  logic [7:0]        program_byte;
  logic              carry_in;
  logic              zero_in;
  logic [3:0]        operand;
  logic [2:0]        command;
  logic              bus_en;
  logic              acc_en;
  logic              out_en;

  modport master (
    output pc, operand, command, bus_en, acc_en, out_en,
    input  program_byte, carry_in, zero_in
  );

  modport slave (
    input  pc, operand, command, bus_en, acc_en, out_en,
    output program_byte, carry_in, zero_in
  );
endinterface
`default_nettype wire

// File: rtl/fetch_decode_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | fetch_decode_unit                                                       |
// | Two-cycle program sequencer driving the 4-bit ALU/accumulator datapath. |
// | Optional macro ILLEGAL_TRAP_EN: reserved opcodes halt and flag illegal. |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module fetch_decode_unit #(
  parameter int ADDR_W       = 12,
  parameter int RESET_VECTOR = 0
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 en,
  fetch_decode_unit_if.master  dp,
  output logic                 flag_c,
  output logic                 flag_z,
`ifdef ILLEGAL_TRAP_EN
  output logic                 illegal_op,
`endif
  output logic                 halted
);

  typedef enum logic [1:0] {
    S_FETCH      = 2'd0,
    S_EXEC       = 2'd1,
    S_FETCH_ADDR = 2'd2,
    S_HALT       = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_VECTOR);
  localparam logic [3:0] c_op_lit   = 4'h1;
  localparam logic [3:0] c_op_addi  = 4'h2;
  localparam logic [3:0] c_op_cmpi  = 4'h3;
  localparam logic [3:0] c_op_nandi = 4'h4;
  localparam logic [3:0] c_op_out   = 4'h5;
  localparam logic [3:0] c_op_jmp   = 4'h6;
  localparam logic [3:0] c_op_jc    = 4'h7;
  localparam logic [3:0] c_op_jnc   = 4'h8;
  localparam logic [3:0] c_op_jz    = 4'h9;
  localparam logic [3:0] c_op_jnz   = 4'hA;
  localparam logic [3:0] c_op_halt  = 4'hF;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_instr;
  logic [2:0]        r_cmd;
  logic              r_bus;
  logic              r_acc;
  logic              r_out;
  logic              r_upd;
  logic              r_flag_c;
  logic              r_flag_z;

  logic [3:0]        w_op;
  logic              w_is_jump;
  logic              w_trap;
  logic [2:0]        w_cmd;
  logic              w_bus;
  logic              w_acc;
  logic              w_out;
  logic              w_upd;
  logic              w_taken;
  logic [11:0]       w_target_raw;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_exec_live;

  assign w_op         = dp.program_byte[7:4];
  assign w_is_jump    = (w_op >= c_op_jmp) && (w_op <= c_op_jnz);
  assign w_target_raw = {r_instr[3:0], dp.program_byte};
  assign w_target     = ADDR_W'(w_target_raw);
  assign w_pc_inc     = r_pc + ADDR_W'(1);

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  assign w_trap     = (w_op >= 4'hB) && (w_op <= 4'hE);
  assign illegal_op = r_illegal;
`else
  assign w_trap = 1'b0;
`endif

  // Decode of the byte on the ROM bus; captured at the FETCH edge so EXEC sees registered controls.
  always_comb begin
    w_cmd = r_cmd;
    w_bus = 1'b0;
    w_acc = 1'b0;
    w_out = 1'b0;
    w_upd = 1'b0;
    case (w_op)
      c_op_lit:   begin w_cmd = 3'b010; w_bus = 1'b1; w_acc = 1'b1; w_upd = 1'b1; end
      c_op_addi:  begin w_cmd = 3'b011; w_bus = 1'b1; w_acc = 1'b1; w_upd = 1'b1; end
      c_op_cmpi:  begin w_cmd = 3'b001; w_bus = 1'b1; w_upd = 1'b1; end
      c_op_nandi: begin w_cmd = 3'b100; w_bus = 1'b1; w_acc = 1'b1; end
      c_op_out:   begin w_cmd = 3'b000; w_out = 1'b1; end
      default:    ;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_instr[7:4])
      c_op_jmp: w_taken = 1'b1;
      c_op_jc:  w_taken = r_flag_c;
      c_op_jnc: w_taken = ~r_flag_c;
      c_op_jz:  w_taken = r_flag_z;
      c_op_jnz: w_taken = ~r_flag_z;
      default:  w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (en) begin
      case (r_state)
        S_FETCH: begin
          if ((w_op == c_op_halt) || w_trap) begin
            w_state_next = S_HALT;
          end else if (w_is_jump) begin
            w_state_next = S_FETCH_ADDR;
          end else begin
            w_state_next = S_EXEC;
          end
        end
        S_EXEC:       w_state_next = S_FETCH;
        S_FETCH_ADDR: w_state_next = S_FETCH;
        default:      w_state_next = S_HALT;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= c_reset_pc;
      r_instr  <= 8'h00;
      r_cmd    <= 3'b000;
      r_bus    <= 1'b0;
      r_acc    <= 1'b0;
      r_out    <= 1'b0;
      r_upd    <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else if (en) begin
      case (r_state)
        S_FETCH: begin
          r_instr <= dp.program_byte;
          r_pc    <= w_pc_inc;
          r_cmd   <= w_cmd;
          r_bus   <= w_bus;
          r_acc   <= w_acc;
          r_out   <= w_out;
          r_upd   <= w_upd;
`ifdef ILLEGAL_TRAP_EN
          if (w_trap) begin
            r_illegal <= 1'b1;
          end
`endif
        end
        S_EXEC: begin
          if (r_upd) begin
            r_flag_c <= dp.carry_in;
            r_flag_z <= dp.zero_in;
          end
        end
        S_FETCH_ADDR: begin
          r_pc <= w_taken ? w_target : w_pc_inc;
        end
        default: ;
      endcase
    end
  end

  // Enables are live only in EXEC and drop at once while the sequencer is stalled.
  assign w_exec_live = (r_state == S_EXEC) && en;

  assign dp.pc      = r_pc;
  assign dp.operand = r_instr[3:0];
  assign dp.command = r_cmd;
  assign dp.bus_en  = r_bus & w_exec_live;
  assign dp.acc_en  = r_acc & w_exec_live;
  assign dp.out_en  = r_out & w_exec_live;
  assign flag_c     = r_flag_c;
  assign flag_z     = r_flag_z;
  assign halted     = (r_state == S_HALT);

endmodule
`default_nettype wire
